pixel_capture: RTL

PIXEL_CAPTURE -- requirements
Module: pixel_capture

---
 rtl/pixel_capture_pkg.sv | 32 +++
 rtl/word_fifo.sv | 54 +++++
 rtl/pixel_capture.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pixel_capture_pkg.sv
// Shared constants for the pixel capture slice: VGA timing, capture window
// defaults and the capture controller state encoding.
package pixel_capture_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned DEF_ROW_LIMIT  = 256;
  localparam int unsigned DEF_COL_START  = 16;
  localparam int unsigned DEF_COL_WIDTH  = 256;
  localparam int unsigned DEF_FIFO_DEPTH = 8;

  localparam int unsigned PIX_PER_WORD = 16;
  localparam int unsigned WORD_W       = 32;
  localparam int unsigned COUNT_W      = 13;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_CAPTURE    = 2'd2,
    ST_DRAIN      = 2'd3
  } cap_state_t;

endpackage

// File: rtl/word_fifo.sv
// First-word-fall-through FIFO for packed pixel words. A push into a full
// FIFO is accepted only when a pop happens on the same edge.
module word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge i_Clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pixel_capture.sv
// Captures a rectangular window of one frame from the sprite renderer scan,
// packs 16 two-bit pixels per 32-bit word and hands them out through a FIFO.
module pixel_capture
  import pixel_capture_pkg::*;
#(
  parameter int ROW_LIMIT  = DEF_ROW_LIMIT,
  parameter int COL_START  = DEF_COL_START,
  parameter int COL_WIDTH  = DEF_COL_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Arm,
  input  logic [9:0]  i_Row,
  input  logic [9:0]  i_Column,
  input  logic [1:0]  i_Pixel,
  output logic [31:0] o_Word,
  output logic        o_Word_Valid,
  input  logic        i_Word_Ready,
  output logic        o_Busy,
  output logic        o_Frame_Done,
  output logic        o_Overflow,
  output logic [12:0] o_Word_Count
);

  localparam logic [10:0] ROW_END   = 11'(ROW_LIMIT);
  localparam logic [10:0] COL_LO    = 11'(COL_START);
  localparam logic [10:0] COL_HI    = 11'(COL_START + COL_WIDTH);
  localparam logic [12:0] COUNT_MAX = '1;

  cap_state_t  state_q;
  cap_state_t  state_d;
  logic [29:0] shift_q;
  logic [3:0]  pack_cnt_q;
  logic [10:0] row_ext;
  logic [10:0] col_ext;
  logic        in_window;
  logic        pack_en;
  logic        arm_clear;
  logic        word_push;
  logic        word_pop;
  logic        push_ok;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] fifo_head;
  logic [31:0] word_d;

  assign row_ext   = {1'b0, i_Row};
  assign col_ext   = {1'b0, i_Column};
  assign in_window = (row_ext < ROW_END) && (col_ext >= COL_LO) && (col_ext < COL_HI);
  assign pack_en   = (state_q == ST_CAPTURE) && in_window;
  assign arm_clear = (state_q == ST_IDLE) && i_Arm;
  assign word_d    = {shift_q, i_Pixel};
  assign word_push = pack_en && (pack_cnt_q == 4'd15);

  assign o_Word_Valid = !fifo_empty;
  assign o_Word       = o_Word_Valid ? fifo_head : '0;
  assign word_pop     = o_Word_Valid && i_Word_Ready;
  assign push_ok      = word_push && (!fifo_full || word_pop);

  word_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_word_fifo (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .push    (word_push),
    .din     (word_d),
    .pop     (word_pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  // Controller state register.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and status outputs; Frame_Done marks the DRAIN->IDLE cycle.
  always_comb begin
    state_d      = state_q;
    o_Busy       = 1'b1;
    o_Frame_Done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_Busy = 1'b0;
        if (i_Arm) state_d = ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME: begin
        if (i_Row == '0 && i_Column == '0) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (row_ext == ROW_END) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_d      = ST_IDLE;
          o_Frame_Done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pixel packer: shift in two bits per in-window pixel, word completes on 16th.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      shift_q    <= '0;
      pack_cnt_q <= '0;
    end else if (arm_clear) begin
      shift_q    <= '0;
      pack_cnt_q <= '0;
    end else if (pack_en) begin
      shift_q    <= word_d[29:0];
      pack_cnt_q <= pack_cnt_q + 4'd1;
    end
  end

  // Accepted-word counter and sticky overflow flag, cleared on arming.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Word_Count <= '0;
      o_Overflow   <= 1'b0;
    end else if (arm_clear) begin
      o_Word_Count <= '0;
      o_Overflow   <= 1'b0;
    end else begin
      if (push_ok && o_Word_Count != COUNT_MAX) o_Word_Count <= o_Word_Count + 13'd1;
      if (word_push && !push_ok)                o_Overflow   <= 1'b1;
    end
  end

endmodule
